disp_mux_n: RTL
===============

// Module: disp_mux_n
// PURPOSE
//  Parametrised N-digit time-multiplexed seven-segment driver; successor to the fixed 3-digit mux.
//  Scans NUM_DIGITS segment patterns onto one shared segment bus with one-hot digit enables.
//  Adds a dead-time gap between digits (anti-ghosting), PWM brightness, per-digit blanking,
//  tear-free frame-latched inputs and a frame_tick pulse. Sits between display formatting logic and pads.
// PARAMETERS
//  NUM_DIGITS    3       digits scanned, >=1
//  SEG_W         8       segment bus width (7 seg + dp)
//  SLOT_CYC      32768   clk cycles per digit slot, > DEAD_CYC+1
//  DEAD_CYC      16      cycles at slot start with all enables inactive, >=1
//  DIM_W         4       brightness code width, >=1
//  EN_ACT_LOW    1       1: digit enable active-low; 0: active-high
//  SEG_OFF       8'hFF   segment pattern driven when dark (all segments off)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  reset, asynchronous, active-low
//  digits_in    in   NUM_DIGITS*SEG_W   digit i pattern at [i*SEG_W +: SEG_W]
//  blank_in     in   NUM_DIGITS         1 = digit i forced dark
//  bright       in   DIM_W              0 = off, all-ones = full on
//  sseg         out  SEG_W              registered segment bus
//  en           out  NUM_DIGITS         registered one-hot digit enable (polarity per EN_ACT_LOW)
//  frame_tick   out  1                  registered 1-cycle pulse, last cycle of last slot
// BEHAVIOUR
//  Reset (rst=0, async): slot_cnt=0, dig_idx=0, pwm_cnt=0, sseg=SEG_OFF, en=all inactive,
//   frame_tick=0, shadow patterns=SEG_OFF, shadow blank=all 1, shadow bright=0. Release: scan from digit 0.
//  slot_cnt counts 0..SLOT_CYC-1 then wraps; on wrap dig_idx increments, NUM_DIGITS-1 wraps to 0.
//  Frame latch: cycle with slot_cnt==0 and dig_idx==0 copies digits_in, blank_in, bright into
//   shadows; input changes mid-frame are invisible until next frame (no tearing).
//  pwm_cnt free-runs 0..2^DIM_W-2 (period 2^DIM_W-1); cleared at each slot start.
//  Lit condition (comb, from state this cycle): slot_cnt>=DEAD_CYC AND !blank_sh[dig_idx]
//   AND pwm_cnt < bright_sh. bright=max -> always lit outside dead time; bright=0 -> never lit.
//  Outputs registered next edge (1-cycle latency from counters):
//   lit: sseg=pat_sh[dig_idx], en=onehot(dig_idx) in selected polarity.
//   not lit: sseg=SEG_OFF, en=all inactive. At most one enable active ever.
//  frame_tick=1 for exactly one cycle following state slot_cnt==SLOT_CYC-1, dig_idx==NUM_DIGITS-1.
//  NUM_DIGITS=1: dig_idx constant 0; dead time and PWM still apply.
//  Counter widths: $clog2(SLOT_CYC), $clog2(NUM_DIGITS) (min 1), DIM_W; no overflow past terminal values.
//  Reset mid-slot: outputs go dark immediately (async), scan restarts at digit 0 with fresh frame latch.
// STRUCTURE
//  disp_pkg (shared header): SEG_OFF default, onehot/polarity helper function, clog2 helper.
//  Sub-module disp_pwm: pwm_cnt + comparator, inputs clk/rst/clr/duty, output on.
//  Top holds slot/digit counters, shadow registers, output registers.
// TESTING (NUM_DIGITS=3, SLOT_CYC=8, DEAD_CYC=2, DIM_W=2, EN_ACT_LOW=1, SEG_OFF=8'hFF)
//  1 Reset held, digits_in=24'h112233 -> sseg=8'hFF, en=3'b111, frame_tick=0; async assert mid-scan same.
//  2 Release, bright=2'b11, blank=0, digits_in={8'h33,8'h22,8'h11} -> per slot 2 cycles dark then
//    6 cycles sseg=8'h11 en=3'b110, then 8'h22/3'b101, then 8'h33/3'b011; repeat, 24-cycle frame.
//  3 frame_tick: exactly one pulse every 24 cycles, one cycle after the digit-2 slot's last cycle.
//  4 bright=2'b01 -> in lit window pattern on 1 cycle of every 3 after dead time; bright=0 -> en=3'b111 always.
//  5 blank_in=3'b010 -> digit 1 slot fully dark (en=3'b111, sseg=8'hFF); digits 0,2 unaffected.
//  6 Change digits_in during digit 1 slot -> displayed values unchanged until next frame's digit 0.
//  All: assertion en never has >1 active bit; sseg==SEG_OFF whenever en all inactive.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed seven-segment display drivers:
// default dark pattern, digit-enable polarity and width helpers.
package disp_pkg;

    localparam logic [7:0]  SEG_OFF_DEF = 8'hFF;
    localparam int unsigned EN_MAX      = 64;

    typedef enum logic {
        EN_POL_HIGH = 1'b0,
        EN_POL_LOW  = 1'b1
    } en_pol_e;

    // Counter width for n states; never below one bit so 1-entry counters stay legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    // One-hot enable for digit idx (or none when on=0), in the requested polarity.
    function automatic logic [EN_MAX-1:0] en_vec(input int unsigned idx,
                                                 input logic        on,
                                                 input en_pol_e     pol);
        logic [EN_MAX-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < EN_MAX; i++) begin
            v[i] = on && (i == idx);
        end
        return (pol == EN_POL_LOW) ? ~v : v;
    endfunction

endpackage

// File: rtl/disp_pwm.sv
// Brightness PWM: free-running counter with period 2^DIM_W-1, restartable per slot,
// compared against the duty code (all-ones = always on, zero = always off).
module disp_pwm
    import disp_pkg::*;
#(
    parameter int unsigned DIM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIM_W-1:0] duty,
    output logic             on
);

    localparam logic [DIM_W-1:0] CNT_LAST = DIM_W'((1 << DIM_W) - 2);

    logic [DIM_W-1:0] pwm_cnt_q;
    logic [DIM_W-1:0] pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        if (clr || (pwm_cnt_q == CNT_LAST)) begin
            pwm_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign on = (pwm_cnt_q < duty);

endmodule

// File: rtl/disp_mux_n.sv
// N-digit time-multiplexed seven-segment driver with dead time, PWM dimming,
// per-digit blanking and frame-latched inputs.
module disp_mux_n
    import disp_pkg::*;
#(
    parameter int unsigned      NUM_DIGITS = 3,
    parameter int unsigned      SEG_W      = 8,
    parameter int unsigned      SLOT_CYC   = 32768,
    parameter int unsigned      DEAD_CYC   = 16,
    parameter int unsigned      DIM_W      = 4,
    parameter bit               EN_ACT_LOW = 1'b1,
    parameter logic [SEG_W-1:0] SEG_OFF    = SEG_W'(SEG_OFF_DEF)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       blank_in,
    input  logic [DIM_W-1:0]            bright,
    output logic [SEG_W-1:0]            sseg,
    output logic [NUM_DIGITS-1:0]       en,
    output logic                        frame_tick
);

    localparam int unsigned SCW = clog2_min1(SLOT_CYC);
    localparam int unsigned DGW = clog2_min1(NUM_DIGITS);

    localparam logic [SCW-1:0] SLOT_LAST  = SCW'(SLOT_CYC - 1);
    localparam logic [SCW-1:0] DEAD_START = SCW'(DEAD_CYC);
    localparam logic [DGW-1:0] DIG_LAST   = DGW'(NUM_DIGITS - 1);
    localparam en_pol_e        EN_POL     = EN_ACT_LOW ? EN_POL_LOW : EN_POL_HIGH;
    localparam logic [NUM_DIGITS-1:0] EN_IDLE = NUM_DIGITS'(en_vec(0, 1'b0, EN_POL));

    logic [SCW-1:0]        slot_q, slot_d;
    logic [DGW-1:0]        dig_q, dig_d;
    logic [SEG_W-1:0]      pat_sh_q [NUM_DIGITS];
    logic [SEG_W-1:0]      pat_sh_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_sh_q, blank_sh_d;
    logic [DIM_W-1:0]      bright_sh_q, bright_sh_d;
    logic [SEG_W-1:0]      sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  ft_q, ft_d;

    logic slot_wrap;
    logic frame_start;
    logic pwm_on;
    logic lit;

    disp_pwm #(
        .DIM_W (DIM_W)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .clr  (slot_wrap),
        .duty (bright_sh_q),
        .on   (pwm_on)
    );

    always_comb begin
        slot_wrap   = (slot_q == SLOT_LAST);
        frame_start = (slot_q == '0) && (dig_q == '0);

        slot_d = slot_wrap ? '0 : slot_q + 1'b1;
        dig_d  = dig_q;
        if (slot_wrap) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end

        // Shadows only move at the first cycle of a frame so a half-updated
        // display word never reaches the pads.
        pat_sh_d    = pat_sh_q;
        blank_sh_d  = blank_sh_q;
        bright_sh_d = bright_sh_q;
        if (frame_start) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                pat_sh_d[i] = digits_in[i*SEG_W +: SEG_W];
            end
            blank_sh_d  = blank_in;
            bright_sh_d = bright;
        end

        lit    = (slot_q >= DEAD_START) && !blank_sh_q[dig_q] && pwm_on;
        sseg_d = lit ? pat_sh_q[dig_q] : SEG_OFF;
        en_d   = NUM_DIGITS'(en_vec(32'(dig_q), lit, EN_POL));
        ft_d   = slot_wrap && (dig_q == DIG_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q      <= '0;
            dig_q       <= '0;
            blank_sh_q  <= '1;
            bright_sh_q <= '0;
            sseg_q      <= SEG_OFF;
            en_q        <= EN_IDLE;
            ft_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                pat_sh_q[i] <= SEG_OFF;
            end
        end else begin
            slot_q      <= slot_d;
            dig_q       <= dig_d;
            blank_sh_q  <= blank_sh_d;
            bright_sh_q <= bright_sh_d;
            sseg_q      <= sseg_d;
            en_q        <= en_d;
            ft_q        <= ft_d;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                pat_sh_q[i] <= pat_sh_d[i];
            end
        end
    end

    assign sseg       = sseg_q;
    assign en         = en_q;
    assign frame_tick = ft_q;

endmodule
